// File: rtl/i2c_target_fifo.sv
// I2C target bridge: oversampled START/STOP and address decode, write bytes land in an
// RX FIFO, read bytes come from a locally loaded TX FIFO. SDA is open-drain (drives 0 only).
module i2c_target_fifo #(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter int         DEPTH       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       ovf,
  output logic       udf,
  input  logic       err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_A_ACK     = 3'd2,
    ST_WR        = 3'd3,
    ST_W_ACK     = 3'd4,
    ST_RD        = 3'd5,
    ST_R_ACK     = 3'd6,
    ST_WAIT_STOP = 3'd7
  } state_t;

  state_t        state_r;
  logic [2:0]    bit_cnt_r;
  logic [7:0]    shift_r;
  logic          phase_r;
  logic          rw_r;
  logic          nack_r;
  logic          sda_oe_r;
  logic          busy_r;
  logic          ovf_r;
  logic          udf_r;

  logic          scl_meta_r, scl_sync_r, scl_prev_r;
  logic          sda_meta_r, sda_sync_r, sda_prev_r;
  logic          scl_rise_s, scl_fall_s, start_s, stop_s;

  logic [7:0]    rx_mem_r [DEPTH];
  logic [7:0]    tx_mem_r [DEPTH];
  logic [PW-1:0] rx_wr_r, rx_rd_r, tx_wr_r, tx_rd_r;
  logic [PW-1:0] rx_count_s, tx_count_s;
  logic          rx_full_s, tx_empty_s;
  logic [7:0]    load_byte_s;

  assign sda = sda_oe_r ? 1'b0 : 1'bz;

  // Synchronizers reset to the idle-bus level so reset never fabricates an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_meta_r <= 1'b1;
      scl_sync_r <= 1'b1;
      scl_prev_r <= 1'b1;
      sda_meta_r <= 1'b1;
      sda_sync_r <= 1'b1;
      sda_prev_r <= 1'b1;
    end else begin
      scl_meta_r <= scl;
      scl_sync_r <= scl_meta_r;
      scl_prev_r <= scl_sync_r;
      sda_meta_r <= sda;
      sda_sync_r <= sda_meta_r;
      sda_prev_r <= sda_sync_r;
    end
  end

  assign scl_rise_s = scl_sync_r & ~scl_prev_r;
  assign scl_fall_s = ~scl_sync_r & scl_prev_r;
  assign start_s    = scl_sync_r & scl_prev_r & sda_prev_r & ~sda_sync_r;
  assign stop_s     = scl_sync_r & scl_prev_r & ~sda_prev_r & sda_sync_r;

  assign rx_count_s  = rx_wr_r - rx_rd_r;
  assign tx_count_s  = tx_wr_r - tx_rd_r;
  assign rx_full_s   = (rx_count_s == DEPTH_P);
  assign tx_empty_s  = (tx_wr_r == tx_rd_r);
  assign load_byte_s = tx_empty_s ? 8'hFF : tx_mem_r[tx_rd_r[AW-1:0]];

  assign rx_valid = (rx_wr_r != rx_rd_r);
  assign rx_data  = rx_mem_r[rx_rd_r[AW-1:0]];
  assign tx_ready = (tx_count_s != DEPTH_P);
  assign busy     = busy_r;
  assign ovf      = ovf_r;
  assign udf      = udf_r;

  // Local side: RX pop and TX push.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_rd_r <= {PW{1'b0}};
      tx_wr_r <= {PW{1'b0}};
      for (int i = 0; i < DEPTH; i++) tx_mem_r[i] <= 8'h00;
    end else begin
      if (rx_valid && rx_ready) rx_rd_r <= rx_rd_r + PW'(1);
      if (tx_valid && tx_ready) begin
        tx_mem_r[tx_wr_r[AW-1:0]] <= tx_data;
        tx_wr_r <= tx_wr_r + PW'(1);
      end
    end
  end

  // Bus-side protocol FSM, including RX push, TX pop and the sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'h00;
      phase_r   <= 1'b0;
      rw_r      <= 1'b0;
      nack_r    <= 1'b0;
      sda_oe_r  <= 1'b0;
      busy_r    <= 1'b0;
      ovf_r     <= 1'b0;
      udf_r     <= 1'b0;
      rx_wr_r   <= {PW{1'b0}};
      tx_rd_r   <= {PW{1'b0}};
      for (int i = 0; i < DEPTH; i++) rx_mem_r[i] <= 8'h00;
    end else begin
      // Clear first so any set assignment below in the same cycle takes precedence.
      if (err_clr) begin
        ovf_r <= 1'b0;
        udf_r <= 1'b0;
      end
      if (start_s) begin
        state_r   <= ST_ADDR;
        bit_cnt_r <= 3'd0;
        phase_r   <= 1'b0;
        sda_oe_r  <= 1'b0;
      end else if (stop_s) begin
        state_r  <= ST_IDLE;
        sda_oe_r <= 1'b0;
        busy_r   <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            busy_r   <= 1'b0;
            sda_oe_r <= 1'b0;
          end
          ST_ADDR: begin
            if (scl_rise_s) begin
              shift_r   <= {shift_r[6:0], sda_sync_r};
              bit_cnt_r <= bit_cnt_r + 3'd1;
              if (bit_cnt_r == 3'd7) begin
                if (shift_r[6:0] == TARGET_ADDR) begin
                  state_r <= ST_A_ACK;
                  busy_r  <= 1'b1;
                  rw_r    <= sda_sync_r;
                  phase_r <= 1'b0;
                end else begin
                  state_r <= ST_WAIT_STOP;
                  busy_r  <= 1'b0;
                end
              end
            end
          end
          ST_A_ACK: begin
            if (scl_fall_s) begin
              if (!phase_r) begin
                sda_oe_r <= 1'b1;
                phase_r  <= 1'b1;
              end else begin
                phase_r   <= 1'b0;
                bit_cnt_r <= 3'd0;
                if (rw_r) begin
                  shift_r  <= load_byte_s;
                  sda_oe_r <= ~load_byte_s[7];
                  if (tx_empty_s) udf_r <= 1'b1;
                  else tx_rd_r <= tx_rd_r + PW'(1);
                  state_r  <= ST_RD;
                end else begin
                  sda_oe_r <= 1'b0;
                  state_r  <= ST_WR;
                end
              end
            end
          end
          ST_WR: begin
            if (scl_rise_s) begin
              shift_r   <= {shift_r[6:0], sda_sync_r};
              bit_cnt_r <= bit_cnt_r + 3'd1;
              if (bit_cnt_r == 3'd7) begin
                state_r <= ST_W_ACK;
                phase_r <= 1'b0;
              end
            end
          end
          ST_W_ACK: begin
            if (scl_fall_s) begin
              if (!phase_r) begin
                phase_r <= 1'b1;
                if (!rx_full_s) begin
                  rx_mem_r[rx_wr_r[AW-1:0]] <= shift_r;
                  rx_wr_r  <= rx_wr_r + PW'(1);
                  sda_oe_r <= 1'b1;
                  nack_r   <= 1'b0;
                end else begin
                  sda_oe_r <= 1'b0;
                  nack_r   <= 1'b1;
                  ovf_r    <= 1'b1;
                end
              end else begin
                phase_r   <= 1'b0;
                sda_oe_r  <= 1'b0;
                bit_cnt_r <= 3'd0;
                state_r   <= nack_r ? ST_WAIT_STOP : ST_WR;
              end
            end
          end
          ST_RD: begin
            // bit_cnt counts bits already clocked out; bit 7 went out on entry.
            if (scl_fall_s) begin
              if (bit_cnt_r == 3'd7) begin
                sda_oe_r <= 1'b0;
                phase_r  <= 1'b0;
                state_r  <= ST_R_ACK;
              end else begin
                shift_r   <= {shift_r[6:0], 1'b0};
                sda_oe_r  <= ~shift_r[6];
                bit_cnt_r <= bit_cnt_r + 3'd1;
              end
            end
          end
          ST_R_ACK: begin
            if (scl_rise_s && !phase_r) begin
              if (sda_sync_r) state_r <= ST_WAIT_STOP;
              else phase_r <= 1'b1;
            end else if (scl_fall_s && phase_r) begin
              phase_r   <= 1'b0;
              bit_cnt_r <= 3'd0;
              shift_r   <= load_byte_s;
              sda_oe_r  <= ~load_byte_s[7];
              if (tx_empty_s) udf_r <= 1'b1;
              else tx_rd_r <= tx_rd_r + PW'(1);
              state_r   <= ST_RD;
            end
          end
          ST_WAIT_STOP: begin
            sda_oe_r <= 1'b0;
          end
          default: begin
            state_r  <= ST_IDLE;
            sda_oe_r <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_fifo.sv
// Bench for i2c_target_fifo: bit-level I2C master, vector table, directed corner cases
// and randomized transactions checked against a queue-based reference model.
module tb_i2c_target_fifo;
  localparam logic [6:0] TA    = 7'h50;
  localparam int         DEPTH = 4;
  localparam int         Q     = 5;

  logic       clk = 1'b0, rst = 1'b1, scl = 1'b1, m_low = 1'b0;
  logic       rx_ready = 1'b0, tx_valid = 1'b0, err_clr = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic       rx_valid, tx_ready, busy, ovf, udf;
  wire        sda;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  i2c_target_fifo #(.TARGET_ADDR(TA), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .ovf(ovf), .udf(udf), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int         total = 0, bad = 0;
  logic [7:0] rx_q[$], tx_q[$];
  logic       m_ovf = 1'b0, m_udf = 1'b0;
  logic [7:0] wbuf [0:7];

  typedef struct packed {
    logic [6:0] addr;
    logic [7:0] data;
    logic       exp_aack;
    logic       exp_busy;
    logic       exp_dack;
    logic       exp_rxv;
    logic [7:0] exp_rxd;
  } vec_t;
  vec_t vec [0:5];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h want %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bit_out(input logic b);
    m_low = ~b; tick(Q); scl = 1'b1; tick(2*Q); scl = 1'b0; tick(Q);
  endtask

  task automatic bit_in(output logic b);
    m_low = 1'b0; tick(Q); scl = 1'b1; tick(Q); b = sda; tick(Q); scl = 1'b0; tick(Q);
  endtask

  task automatic i2c_start();
    m_low = 1'b0; tick(Q); scl = 1'b1; tick(Q); m_low = 1'b1; tick(Q); scl = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; tick(Q); scl = 1'b1; tick(Q); m_low = 1'b0; tick(2*Q);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) bit_out(d[i]);
    bit_in(ack);
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      bit_in(b);
      d[i] = b;
    end
    bit_out(ack);
  endtask

  task automatic reset_model();
    rx_q.delete(); tx_q.delete(); m_ovf = 1'b0; m_udf = 1'b0;
  endtask

  task automatic m_write(input logic [6:0] a, input int n);
    logic ak, exp_d;
    i2c_start();
    send_byte({a, 1'b0}, ak);
    chk1("wr_addr_ack", ak, (a == TA) ? 1'b0 : 1'b1);
    chk1("wr_busy", busy, a == TA);
    for (int i = 0; i < n; i++) begin
      send_byte(wbuf[i], ak);
      if (a != TA) exp_d = 1'b1;
      else if (rx_q.size() < DEPTH) begin exp_d = 1'b0; rx_q.push_back(wbuf[i]); end
      else begin exp_d = 1'b1; m_ovf = 1'b1; end
      chk1("wr_data_ack", ak, exp_d);
      if (exp_d) break;
    end
    i2c_stop();
    chk1("wr_busy_stop", busy, 1'b0);
    chk1("wr_ovf", ovf, m_ovf);
    chk1("wr_rx_valid", rx_valid, rx_q.size() != 0);
  endtask

  task automatic m_read(input int n);
    logic ak;
    logic [7:0] d, exp;
    i2c_start();
    send_byte({TA, 1'b1}, ak);
    chk1("rd_addr_ack", ak, 1'b0);
    chk1("rd_busy", busy, 1'b1);
    for (int i = 0; i < n; i++) begin
      if (tx_q.size() != 0) exp = tx_q.pop_front();
      else begin exp = 8'hFF; m_udf = 1'b1; end
      recv_byte(d, i == n - 1);
      chk8("rd_byte", d, exp);
    end
    i2c_stop();
    chk1("rd_busy_stop", busy, 1'b0);
    chk1("rd_udf", udf, m_udf);
    chk1("rd_tx_ready", tx_ready, tx_q.size() < DEPTH);
  endtask

  task automatic m_push(input logic [7:0] d);
    chk1("push_tx_ready", tx_ready, tx_q.size() < DEPTH);
    tx_data = d; tx_valid = 1'b1; tick(1); tx_valid = 1'b0;
    if (tx_q.size() < DEPTH) tx_q.push_back(d);
  endtask

  task automatic m_pop();
    chk1("pop_rx_valid", rx_valid, rx_q.size() != 0);
    if (rx_q.size() != 0) chk8("pop_rx_data", rx_data, rx_q[0]);
    rx_ready = 1'b1; tick(1); rx_ready = 1'b0;
    if (rx_q.size() != 0) void'(rx_q.pop_front());
  endtask

  task automatic m_clr();
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    m_ovf = 1'b0; m_udf = 1'b0;
    chk1("clr_ovf", ovf, 1'b0);
    chk1("clr_udf", udf, 1'b0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ak, dk;
    logic [6:0] ra;
    int n;

    vec[0] = '{7'h50, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5};
    vec[1] = '{7'h51, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
    vec[2] = '{7'h50, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00};
    vec[3] = '{7'h28, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
    vec[4] = '{7'h50, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 8'hFF};
    vec[5] = '{7'h50, 8'h81, 1'b0, 1'b1, 1'b0, 1'b1, 8'h81};

    rst = 1'b1; tick(4); rst = 1'b0; tick(2);
    chk1("rst_sda", sda, 1'b1);
    chk1("rst_rx_valid", rx_valid, 1'b0);
    chk1("rst_tx_ready", tx_ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_ovf", ovf, 1'b0);
    chk1("rst_udf", udf, 1'b0);
    chk8("rst_rx_data", rx_data, 8'h00);

    for (int i = 0; i < 6; i++) begin
      i2c_start();
      send_byte({vec[i].addr, 1'b0}, ak);
      chk1("tbl_addr_ack", ak, vec[i].exp_aack);
      chk1("tbl_busy", busy, vec[i].exp_busy);
      send_byte(vec[i].data, dk);
      chk1("tbl_data_ack", dk, vec[i].exp_dack);
      i2c_stop();
      chk1("tbl_busy_stop", busy, 1'b0);
      chk1("tbl_rx_valid", rx_valid, vec[i].exp_rxv);
      if (vec[i].exp_rxv) chk8("tbl_rx_data", rx_data, vec[i].exp_rxd);
      rx_ready = 1'b1; tick(1); rx_ready = 1'b0;
    end
    chk1("tbl_empty", rx_valid, 1'b0);

    // Read of a preloaded byte, then a read from an empty TX FIFO.
    m_push(8'h3C);
    m_read(1);
    chk1("rd_3c_udf", udf, 1'b0);
    m_read(1);
    chk1("rd_empty_udf", udf, 1'b1);
    m_clr();

    // Fill RX with four writes, fifth is NACKed and flags overflow.
    for (int k = 1; k <= 5; k++) begin
      wbuf[0] = 8'(k);
      m_write(TA, 1);
    end
    chk1("ovf_set", ovf, 1'b1);
    for (int k = 0; k < 4; k++) m_pop();
    chk1("ovf_drained", rx_valid, 1'b0);
    m_clr();

    // Multi-byte read running past the TX contents.
    m_push(8'h5A); m_push(8'hC3);
    m_read(3);
    m_clr();

    // Reset during address bit 3 discards state; the next write still works.
    wbuf[0] = 8'h11; m_write(TA, 1);
    i2c_start();
    bit_out(1'b1); bit_out(1'b0); bit_out(1'b1);
    m_low = 1'b0;
    rst = 1'b1; tick(1);
    chk1("rst_mid_sda", sda, 1'b1);
    chk1("rst_mid_busy", busy, 1'b0);
    chk1("rst_mid_rx_valid", rx_valid, 1'b0);
    rst = 1'b0; reset_model(); tick(2);
    i2c_stop();
    wbuf[0] = 8'h77; m_write(TA, 1);
    m_pop();

    // Reset while the target holds SDA low for a read data bit.
    m_push(8'h00);
    i2c_start();
    send_byte({TA, 1'b1}, ak);
    chk1("rd_drv_ack", ak, 1'b0);
    tick(2);
    chk1("rd_drv_low", sda, 1'b0);
    rst = 1'b1; tick(1);
    chk1("rd_rst_release", sda, 1'b1);
    rst = 1'b0; reset_model(); tick(2);
    i2c_stop();

    for (int r = 0; r < 40; r++) begin
      case ($urandom_range(0, 4))
        0: begin
          n = $urandom_range(1, 3);
          for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom_range(0, 255));
          ra = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : TA;
          m_write(ra, n);
        end
        1: m_read($urandom_range(1, 3));
        2: m_push(8'($urandom_range(0, 255)));
        3: m_pop();
        default: m_clr();
      endcase
    end
    while (rx_q.size() != 0) m_pop();
    chk1("final_rx_valid", rx_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
